ttt_board_ctrl: RTL

Sequential game controller directly downstream of the row/col-to-square decoder. It consumes the decoder's 9-bit one-hot `square` together with a one-cycle `place` strobe. It holds the X and O occupancy boards, alternates turns, rejects illegal moves, and detects win and draw. Its outputs drive the display and status logic.

---
 rtl/ttt_pkg.sv | 46 ++++
 rtl/ttt_win_detect.sv | 24 ++
 rtl/ttt_board_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ttt_pkg.sv
// ttt_pkg
//   Shared definitions for the tic-tac-toe board controller: FSM state
//   encoding, the eight winning-line masks, player and winner encodings,
//   and a one-hot test helper.
package ttt_pkg;

  localparam int N_SQUARES = 9;
  localparam int N_LINES   = 8;

  typedef enum logic [1:0] {
    S_X_TURN = 2'd0,
    S_O_TURN = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } ttt_state_t;

  // Index order matches win_line bit order:
  //   [0..2] rows top..bottom, [3..5] columns left..right,
  //   [6] main diagonal, [7] anti-diagonal.
  localparam logic [N_LINES-1:0][N_SQUARES-1:0] WIN_MASKS = {
    9'h054,  // [7] anti-diagonal 2,4,6
    9'h111,  // [6] main diagonal 0,4,8
    9'h124,  // [5] column right
    9'h092,  // [4] column middle
    9'h049,  // [3] column left
    9'h1C0,  // [2] row bottom
    9'h038,  // [1] row middle
    9'h007   // [0] row top
  };

  localparam logic PLAYER_X = 1'b0;
  localparam logic PLAYER_O = 1'b1;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_X    = 2'b01;
  localparam logic [1:0] WINNER_O    = 2'b10;

  localparam logic [3:0] MAX_MOVES = 4'd9;

  // True when exactly one bit of v is set: non-zero and clearing the
  // lowest set bit leaves nothing behind.
  function automatic logic is_onehot9(input logic [N_SQUARES-1:0] v);
    return (v != '0) && ((v & (v - 9'd1)) == '0);
  endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// ttt_win_detect
//   Purely combinational line detector for a single player's board.
//   Ports:
//     i_board    [8:0] occupancy of one player, row-major, bit 0 top-left
//     o_win_line [7:0] one bit per completed line (see WIN_MASKS order)
//     o_any_win        OR of o_win_line
module ttt_win_detect
  import ttt_pkg::*;
(
  input  logic [N_SQUARES-1:0] i_board,
  output logic [N_LINES-1:0]   o_win_line,
  output logic                 o_any_win
);

  genvar gi;
  generate
    for (gi = 0; gi < N_LINES; gi++) begin : g_line
      assign o_win_line[gi] = ((i_board & WIN_MASKS[gi]) == WIN_MASKS[gi]);
    end
  endgenerate

  assign o_any_win = |o_win_line;

endmodule

// File: rtl/ttt_board_ctrl.sv
// ttt_board_ctrl
//   Tic-tac-toe game controller. Accepts one-hot square moves, keeps the
//   X and O boards, alternates turns, flags illegal moves and reports
//   win / draw.
//   Ports:
//     clk, rst          clock and synchronous active-high reset
//     square   [8:0]    one-hot target square, row-major
//     place             one-cycle move request
//     new_game          synchronous clear, same effect as rst
//     ready             a turn state is active
//     turn              player to move (0 = X, 1 = O)
//     x_board  [8:0]    squares held by X
//     o_board  [8:0]    squares held by O
//     illegal           one-cycle pulse after a rejected move
//     game_over         game finished
//     winner   [1:0]    00 none/draw, 01 X, 10 O
//     draw              finished with no winner
//     win_line [7:0]    completed lines of the winner
module ttt_board_ctrl
  import ttt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] square,
  input  logic       place,
  input  logic       new_game,
  output logic       ready,
  output logic       turn,
  output logic [8:0] x_board,
  output logic [8:0] o_board,
  output logic       illegal,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       draw,
  output logic [7:0] win_line
);

  ttt_state_t r_state;
  logic       r_turn;
  logic [8:0] r_x_board;
  logic [8:0] r_o_board;
  logic [3:0] r_count;
  logic       r_illegal;
  logic [1:0] r_winner;
  logic       r_draw;
  logic [7:0] r_win_line;

  ttt_state_t w_state_next;
  logic       w_turn_next;
  logic [8:0] w_x_board_next;
  logic [8:0] w_o_board_next;
  logic [3:0] w_count_next;
  logic       w_illegal_next;
  logic [1:0] w_winner_next;
  logic       w_draw_next;
  logic [7:0] w_win_line_next;

  logic       w_in_turn;
  logic       w_legal;
  logic [8:0] w_mover_board;
  logic [7:0] w_win_line;
  logic       w_any_win;

  assign w_in_turn = (r_state == S_X_TURN) || (r_state == S_O_TURN);

  // Legal only when the target is a single, currently free square.
  assign w_legal = w_in_turn && place && is_onehot9(square) &&
                   ((square & (r_x_board | r_o_board)) == '0);

  // r_turn is held through S_CHECK, so it still names the player who
  // just moved and selects that player's board for line detection.
  assign w_mover_board = (r_turn == PLAYER_O) ? r_o_board : r_x_board;

  ttt_win_detect u_win_detect (
    .i_board    (w_mover_board),
    .o_win_line (w_win_line),
    .o_any_win  (w_any_win)
  );

  always_comb begin
    w_state_next    = r_state;
    w_turn_next     = r_turn;
    w_x_board_next  = r_x_board;
    w_o_board_next  = r_o_board;
    w_count_next    = r_count;
    w_illegal_next  = 1'b0;
    w_winner_next   = r_winner;
    w_draw_next     = r_draw;
    w_win_line_next = r_win_line;

    case (r_state)
      S_X_TURN, S_O_TURN: begin
        if (place) begin
          if (w_legal) begin
            if (r_turn == PLAYER_O) begin
              w_o_board_next = r_o_board | square;
            end else begin
              w_x_board_next = r_x_board | square;
            end
            w_count_next = (r_count == MAX_MOVES) ? r_count : r_count + 4'd1;
            w_state_next = S_CHECK;
          end else begin
            w_illegal_next = 1'b1;
          end
        end
      end

      S_CHECK: begin
        // A completed line wins even on the 9th move.
        if (w_any_win) begin
          w_winner_next   = (r_turn == PLAYER_O) ? WINNER_O : WINNER_X;
          w_win_line_next = w_win_line;
          w_state_next    = S_DONE;
        end else if (r_count == MAX_MOVES) begin
          w_draw_next  = 1'b1;
          w_state_next = S_DONE;
        end else begin
          w_turn_next  = ~r_turn;
          w_state_next = (r_turn == PLAYER_O) ? S_X_TURN : S_O_TURN;
        end
      end

      default: begin
        // S_DONE holds everything until a clear.
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      r_state    <= S_X_TURN;
      r_turn     <= PLAYER_X;
      r_x_board  <= '0;
      r_o_board  <= '0;
      r_count    <= '0;
      r_illegal  <= 1'b0;
      r_winner   <= WINNER_NONE;
      r_draw     <= 1'b0;
      r_win_line <= '0;
    end else begin
      r_state    <= w_state_next;
      r_turn     <= w_turn_next;
      r_x_board  <= w_x_board_next;
      r_o_board  <= w_o_board_next;
      r_count    <= w_count_next;
      r_illegal  <= w_illegal_next;
      r_winner   <= w_winner_next;
      r_draw     <= w_draw_next;
      r_win_line <= w_win_line_next;
    end
  end

  assign ready     = w_in_turn;
  assign turn      = r_turn;
  assign x_board   = r_x_board;
  assign o_board   = r_o_board;
  assign illegal   = r_illegal;
  assign game_over = (r_state == S_DONE);
  assign winner    = r_winner;
  assign draw      = r_draw;
  assign win_line  = r_win_line;

endmodule
